// File: rtl/sqsum_if.sv
// sqsum_if: beat-in / result-out handshake bundle for sqsum_accum.
interface sqsum_if #(
    parameter int SQ_W  = 17,
    parameter int ACC_W = 21
);
    logic             in_valid;
    logic             in_ready;
    logic [SQ_W-1:0]  square;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    modport master (
        output in_valid, square, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, square, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/sqsum_accum.sv
// sqsum_accum: sums N_TERMS squares per window into one handshaked result.
// Define SQSUM_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module sqsum_accum #(
    parameter int SQ_W    = 17,
    parameter int N_TERMS = 16,
    parameter int CNT_W   = 5,
    parameter int ACC_W   = 21
) (
    input logic    clk,
    input logic    rst,
    input logic    clr,
    sqsum_if.slave bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt, sum_q;
    logic [ACC_W:0]   add;
    logic [CNT_W-1:0] cnt;
    logic             ovf, ovf_nxt, ovf_q, beat, last;

    assign add     = {1'b0, acc} + (ACC_W+1)'(bus.square);
    assign ovf_nxt = ovf | add[ACC_W];
    assign beat    = bus.in_valid & bus.in_ready;
    assign last    = cnt == CNT_W'(N_TERMS - 1);
`ifdef SQSUM_SAT_EN
    // once clamped, every later add carries or adds zero, so it stays clamped
    assign acc_nxt = add[ACC_W] ? '1 : add[ACC_W-1:0];
`else
    assign acc_nxt = add[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == ACCUM ? ((beat && last) ? HOLD : ACCUM)
                                   : (bus.out_ready ? ACCUM : HOLD);
    end

    always_comb begin
        bus.in_ready  = state == ACCUM && !clr;
        bus.out_valid = state == HOLD;
        bus.out_sum   = sum_q;
        bus.out_ovf   = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else if (state == ACCUM && clr) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (beat && last) begin
            sum_q <= acc_nxt;
            ovf_q <= ovf_nxt;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (beat) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            ovf <= ovf_nxt;
        end
    end
endmodule

// File: tb/tb_sqsum_accum.sv
// tb_sqsum_accum: directed and random windows checked against a queue-based sum model.
module tb_sqsum_accum;
    localparam int N     = 4;
    localparam int SQ_W  = 17;
    localparam int ACC_W = 17;

    logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
    int   n_cmp = 0, n_err = 0;

    logic [SQ_W-1:0]  q[$];
    logic             hold = 1'b0;
    logic [ACC_W-1:0] exp_sum = '0;
    logic             exp_ovf = 1'b0;

    always #5 clk = ~clk;

    sqsum_if #(.SQ_W(SQ_W), .ACC_W(ACC_W)) bus ();

    sqsum_accum #(.SQ_W(SQ_W), .N_TERMS(N), .CNT_W(3), .ACC_W(ACC_W)) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // the window result follows from the true integer total of the accepted beats
    task automatic close_window();
        longint total = 0;
        foreach (q[i]) total += q[i];
        exp_ovf = total > longint'({ACC_W{1'b1}});
`ifdef SQSUM_SAT_EN
        exp_sum = exp_ovf ? '1 : ACC_W'(total);
`else
        exp_sum = ACC_W'(total);
`endif
        hold = 1'b1;
        q.delete();
    endtask

    task automatic cyc(input logic v, input logic [SQ_W-1:0] sq, input logic ordy, input logic c);
        @(negedge clk);
        bus.in_valid  = v;
        bus.square    = sq;
        bus.out_ready = ordy;
        clr           = c;
        #1;
        check("in_ready", bus.in_ready, !hold && !c);
        check("out_valid", bus.out_valid, hold);
        if (hold) begin
            check("out_sum", bus.out_sum, exp_sum);
            check("out_ovf", bus.out_ovf, exp_ovf);
            if (ordy) hold = 1'b0;
        end else if (c) q.delete();
        else if (v) begin
            q.push_back(sq);
            if (q.size() == N) close_window();
        end
    endtask

    task automatic do_rst();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        clr          = 1'b0;
        @(negedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_out_ovf", bus.out_ovf, 1'b0);
        rst = 1'b0;
        q.delete();
        hold = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.square    = '0;
        bus.out_ready = 1'b1;
        do_rst();
        foreach (q[i]) check("noop", 0, 0);
        cyc(1, 1, 1, 0); cyc(1, 4, 1, 0); cyc(1, 9, 1, 0); cyc(1, 16, 1, 0);
        cyc(1, 50, 1, 0);
        check("sum30", bus.out_sum, 30);
        for (int i = 0; i < 8; i++) cyc(i % 2 == 0, 100, 1, 0);
        cyc(0, 0, 1, 0);
        check("sum400", bus.out_sum, 400);
        for (int i = 0; i < 4; i++) cyc(1, SQ_W'(i + 3), 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 17'd999, 0, 0);
        cyc(1, 17'd999, 1, 0);
        cyc(1, 5, 1, 0); cyc(1, 7, 1, 0); cyc(1, 9, 1, 1);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0);
        cyc(0, 0, 1, 0);
        check("sum4", bus.out_sum, 4);
        for (int i = 0; i < 4; i++) cyc(1, 17'h1FFFF, 0, 0);
        cyc(0, 0, 1, 0);
        check("ovf_flag", bus.out_ovf, 1'b1);
`ifdef SQSUM_SAT_EN
        check("ovf_sum", bus.out_sum, 17'h1FFFF);
`else
        check("ovf_sum", bus.out_sum, 17'h1FFFC);
`endif
        for (int i = 0; i < 3; i++) cyc(1, 17'd40, 1, 0);
        do_rst();
        for (int i = 0; i < 4; i++) cyc(1, 17'd40, 0, 0);
        cyc(0, 0, 0, 0);
        do_rst();
        for (int i = 0; i < 4; i++) cyc(1, 2, 1, 0);
        cyc(0, 0, 1, 0);
        check("sum8", bus.out_sum, 8);
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 1) != 0 ? SQ_W'($urandom_range(0, 1000)) : SQ_W'($urandom),
                $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
